cnu_serial: RTL and testbench

CNU_SERIAL -- requirements
Module: cnu_serial

---
 rtl/ldpc_pkg.sv | 31 +++
 rtl/cnu_serial_if.sv | 40 ++++
 rtl/cnu_mag.sv | 28 ++
 rtl/cnu_serial.sv | 177 +++++++++++++++++
 tb/tb_cnu_serial.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_pkg
//  Description : Shared constants, check-node FSM state encoding and the
//                saturating-magnitude helper for the LDPC check-node slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package ldpc_pkg;

    // Default message widths: r messages are DATA_W bits, q carries EXT_W more
    localparam int DATA_W = 6;
    localparam int EXT_W  = 3;

    // Check-node frame sequencing: gather all edges, then stream results
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } cnu_state_t;

    // |v| clipped to the largest magnitude a width-bit two's-complement
    // message can carry; the most negative input clips like any other
    function automatic int sat_mag(input int v, input int width);
        int a;
        int lim;
        a   = (v < 0) ? -v : v;
        lim = (1 << (width - 1)) - 1;
        return (a > lim) ? lim : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnu_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : cnu_serial_if
//  Description : Stream bundle between variable nodes and the serial
//                check node: q input stream and r/syn output stream.
//                The check node attaches as slave, the variable side as master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cnu_serial_if
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int ext_w  = EXT_W,
    parameter int DC     = 6
);
    localparam int c_SUM_W = data_w + ext_w;
    localparam int c_IDX_W = $clog2(DC);

    logic [c_SUM_W-1:0] q;
    logic               q_valid;
    logic               q_ready;
    logic [data_w-1:0]  r;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_last;
    logic               r_valid;
    logic               r_ready;
    logic               syn;

    modport master (
        output q, q_valid, r_ready,
        input  q_ready, r, r_idx, r_last, r_valid, syn
    );

    modport slave (
        input  q, q_valid, r_ready,
        output q_ready, r, r_idx, r_last, r_valid, syn
    );

endinterface
`default_nettype wire

// File: rtl/cnu_mag.sv
`default_nettype none
// ============================================================================
//  Module      : cnu_mag
//  Description : Splits an extended-width q message into its sign bit and a
//                magnitude saturated to the r-message range (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
module cnu_mag
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int ext_w  = EXT_W
) (
    input  wire logic [data_w+ext_w-1:0] i_q,
    output logic                         o_sign,
    output logic [data_w-2:0]            o_mag
);
    localparam int c_SUM_W = data_w + ext_w;
    localparam int c_MAG_W = data_w - 1;

    // Sign straight from the MSB; magnitude via the shared saturating helper
    always_comb begin
        o_sign = i_q[c_SUM_W-1];
        o_mag  = c_MAG_W'(sat_mag(int'($signed(i_q)), data_w));
    end

endmodule
`default_nettype wire

// File: rtl/cnu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : cnu_serial
//  Description : Serial min-sum check-node unit. Collects DC q messages,
//                tracking the two smallest magnitudes and the sign parity,
//                then emits DC r messages plus the frame syndrome.
//                Build option: CNU_OFFSET_EN enables offset-min-sum
//                (emitted magnitude reduced by OFFSET, floored at zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module cnu_serial
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int ext_w  = EXT_W,
    parameter int DC     = 6,
    parameter int OFFSET = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    cnu_serial_if.slave  bus
);
    localparam int                 c_MAG_W = data_w - 1;
    localparam int                 c_IDX_W = $clog2(DC);
    localparam logic [c_MAG_W-1:0] c_MAG_MAX = '1;
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(DC - 1);

    // Elaboration-time parameter sanity
    if (DC < 2) begin : g_chk_dc
        $error("cnu_serial: DC must be at least 2");
    end
    if (OFFSET < 0) begin : g_chk_offset
        $error("cnu_serial: OFFSET must be non-negative");
    end

    cnu_state_t r_state, w_state_nxt;

    logic [c_IDX_W-1:0] r_cnt;
    logic [c_MAG_W-1:0] r_min1, r_min2;
    logic [c_IDX_W-1:0] r_idx1;
    logic               r_sacc;
    logic [DC-1:0]      r_signs;
    logic [data_w-1:0]  r_r;
    logic [c_IDX_W-1:0] r_ridx;
    logic               r_rlast, r_rvalid, r_syn;

    logic               w_q_ready, w_accept, w_fire;
    logic               w_qsign;
    logic [c_MAG_W-1:0] w_qmag;
    logic [c_MAG_W-1:0] w_min1_n, w_min2_n;
    logic [c_IDX_W-1:0] w_idx1_n;
    logic               w_sacc_n;
    logic [DC-1:0]      w_signs_n;
    logic [c_IDX_W-1:0] w_e;
    logic [c_MAG_W-1:0] w_sel, w_omag;
    logic               w_osgn;
    logic [data_w-1:0]  w_mext, w_r;

    cnu_mag #(.data_w(data_w), .ext_w(ext_w)) u_mag (
        .i_q    (bus.q),
        .o_sign (w_qsign),
        .o_mag  (w_qmag)
    );

    assign w_q_ready = (r_state == ST_COLLECT);
    assign w_accept  = bus.q_valid & w_q_ready;
    assign w_fire    = r_rvalid & bus.r_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_COLLECT;
        else     r_state <= w_state_nxt;
    end

    // Next state: leave COLLECT on the last edge, leave EMIT on the last handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: if (w_accept && r_cnt == c_LAST)  w_state_nxt = ST_EMIT;
            ST_EMIT:    if (w_fire && r_rlast)            w_state_nxt = ST_COLLECT;
            default:                                      w_state_nxt = ST_COLLECT;
        endcase
    end

    // Running min1/min2/sign update for the edge being accepted this cycle
    always_comb begin
        w_min1_n  = r_min1;
        w_min2_n  = r_min2;
        w_idx1_n  = r_idx1;
        w_sacc_n  = r_sacc;
        w_signs_n = r_signs;
        if (w_accept) begin
            w_signs_n[r_cnt] = w_qsign;
            w_sacc_n         = r_sacc ^ w_qsign;
            if (w_qmag < r_min1) begin
                w_min2_n = r_min1;
                w_min1_n = w_qmag;
                w_idx1_n = r_cnt;
            end else if (w_qmag < r_min2) begin
                w_min2_n = w_qmag;
            end
        end
    end

    // Result for the edge to present next: edge 0 on entry, else the following edge
    always_comb begin
        w_e   = (r_state == ST_COLLECT) ? '0 : r_ridx + 1'b1;
        w_sel = (w_e == w_idx1_n) ? w_min2_n : w_min1_n;
`ifdef CNU_OFFSET_EN
        w_omag = (w_sel > c_MAG_W'(OFFSET)) ? w_sel - c_MAG_W'(OFFSET) : '0;
`else
        w_omag = w_sel;
`endif
        w_osgn = w_sacc_n ^ w_signs_n[w_e];
        w_mext = {1'b0, w_omag};
        // Negating a zero magnitude yields zero, so no sign on zero results
        w_r    = w_osgn ? (~w_mext + 1'b1) : w_mext;
    end

    // Frame accumulators and registered output stream
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_min1   <= c_MAG_MAX;
            r_min2   <= c_MAG_MAX;
            r_idx1   <= '0;
            r_sacc   <= 1'b0;
            r_signs  <= '0;
            r_r      <= '0;
            r_ridx   <= '0;
            r_rlast  <= 1'b0;
            r_rvalid <= 1'b0;
            r_syn    <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= r_cnt + 1'b1;
            r_min1  <= w_min1_n;
            r_min2  <= w_min2_n;
            r_idx1  <= w_idx1_n;
            r_sacc  <= w_sacc_n;
            r_signs <= w_signs_n;
            if (r_cnt == c_LAST) begin
                r_rvalid <= 1'b1;
                r_r      <= w_r;
                r_ridx   <= '0;
                r_rlast  <= 1'b0;
                r_syn    <= w_sacc_n;
            end
        end else if (w_fire) begin
            if (r_rlast) begin
                r_cnt    <= '0;
                r_min1   <= c_MAG_MAX;
                r_min2   <= c_MAG_MAX;
                r_idx1   <= '0;
                r_sacc   <= 1'b0;
                r_signs  <= '0;
                r_r      <= '0;
                r_ridx   <= '0;
                r_rlast  <= 1'b0;
                r_rvalid <= 1'b0;
                r_syn    <= 1'b0;
            end else begin
                r_r     <= w_r;
                r_ridx  <= w_e;
                r_rlast <= (w_e == c_LAST);
            end
        end
    end

    assign bus.q_ready = w_q_ready;
    assign bus.r       = r_r;
    assign bus.r_idx   = r_ridx;
    assign bus.r_last  = r_rlast;
    assign bus.r_valid = r_rvalid;
    assign bus.syn     = r_syn;

endmodule
`default_nettype wire

// File: tb/tb_cnu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnu_serial
//  Description : Directed self-checking bench for cnu_serial (data_w=6,
//                ext_w=3, DC=4, OFFSET=1). Expected r values are hand-derived
//                for both plain and offset (CNU_OFFSET_EN) builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnu_serial;
    localparam int DW = 6;
    localparam int EW = 3;
    localparam int SW = DW + EW;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnu_serial_if #(.data_w(DW), .ext_w(EW), .DC(N)) bus ();

    cnu_serial #(.data_w(DW), .ext_w(EW), .DC(N), .OFFSET(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Frames: A basic, B tie, C most-negative input, D small, E even parity, F saturation
    int qin [6][4] = '{'{5, -3, 7, 20}, '{4, 4, -9, 10}, '{-256, 1, 2, 3},
                       '{1, -1, 2, 2}, '{2, -6, -1, 8}, '{255, -40, 31, 30}};
    int sy  [6]    = '{1, 1, 1, 1, 0, 1};
`ifdef CNU_OFFSET_EN
    int ex  [6][4] = '{'{-2, 4, -2, -2}, '{-3, -3, 3, -3}, '{0, -1, 0, 0},
                       '{0, 0, 0, 0}, '{0, 0, -1, 0}, '{-29, 29, -29, -30}};
`else
    int ex  [6][4] = '{'{-3, 5, -3, -3}, '{-4, -4, 4, -4}, '{1, -2, -1, -1},
                       '{-1, 1, -1, -1}, '{1, -1, -2, 1}, '{-30, 30, -30, -31}};
`endif

    task automatic chk(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_rst();
        chk("rst q_ready", 32'(bus.q_ready), 1);
        chk("rst r_valid", 32'(bus.r_valid), 0);
        chk("rst r",       32'(bus.r),       0);
        chk("rst r_idx",   32'(bus.r_idx),   0);
        chk("rst r_last",  32'(bus.r_last),  0);
        chk("rst syn",     32'(bus.syn),     0);
    endtask

    task automatic send(input int f);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.q       = SW'(qin[f][i]);
            bus.q_valid = 1'b1;
            chk($sformatf("f%0d q_ready[%0d]", f, i), 32'(bus.q_ready), 1);
        end
        @(negedge clk);
        bus.q_valid = 1'b0;
        chk($sformatf("f%0d latency", f), 32'(bus.r_valid), 1);
    endtask

    task automatic recv(input int f, input int start);
        for (int i = start; i < N; i++) begin
            int t = 0;
            while (!bus.r_valid && t < 8) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("f%0d r_valid[%0d]", f, i), 32'(bus.r_valid), 1);
            chk($sformatf("f%0d r[%0d]", f, i), 32'($signed(bus.r)), ex[f][i]);
            chk($sformatf("f%0d r_idx[%0d]", f, i), 32'(bus.r_idx), i);
            chk($sformatf("f%0d r_last[%0d]", f, i), 32'(bus.r_last), (i == N - 1) ? 1 : 0);
            chk($sformatf("f%0d syn[%0d]", f, i), 32'(bus.syn), sy[f]);
            @(negedge clk);
        end
        chk($sformatf("f%0d end r_valid", f), 32'(bus.r_valid), 0);
        chk($sformatf("f%0d end q_ready", f), 32'(bus.q_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.q       = '0;
        bus.q_valid = 1'b0;
        bus.r_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_rst();
        rst = 1'b0;

        // Plain frames covering basic, tie, saturation and parity cases
        for (int f = 0; f < 6; f++) begin
            send(f);
            recv(f, 0);
        end

        // Output stall at edge 1 with q_valid asserted against a busy node
        send(0);
        chk("stall r0", 32'($signed(bus.r)), ex[0][0]);
        @(negedge clk);
        bus.r_ready = 1'b0;
        bus.q       = SW'(7);
        bus.q_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall r[%0d]", k),     32'($signed(bus.r)), ex[0][1]);
            chk($sformatf("stall idx[%0d]", k),   32'(bus.r_idx),   1);
            chk($sformatf("stall syn[%0d]", k),   32'(bus.syn),     1);
            chk($sformatf("stall valid[%0d]", k), 32'(bus.r_valid), 1);
            chk($sformatf("stall qrdy[%0d]", k),  32'(bus.q_ready), 0);
        end
        bus.r_ready = 1'b1;
        bus.q_valid = 1'b0;
        recv(0, 1);
        send(1);
        recv(1, 0);

        // Reset after two accepted edges
        @(negedge clk);
        bus.q = SW'(5); bus.q_valid = 1'b1;
        @(negedge clk);
        bus.q = SW'(-3);
        @(negedge clk);
        bus.q_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_rst();
        rst = 1'b0;
        send(0);
        recv(0, 0);

        // Reset in the middle of emission
        send(0);
        @(negedge clk);
        chk("mid r_idx", 32'(bus.r_idx), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_rst();
        rst = 1'b0;
        send(0);
        recv(0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
